// File: rtl/dev_mem_arbiter_if.sv
// Request/response bundle between one requester and the device RAM arbiter.
// The requester drives req_* fields and receives a one-cycle rsp_* strobe.
interface dev_mem_arbiter_if #(
  parameter int ADDR = 16,
  parameter int DATA = 128
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [ADDR-1:0] req_addr;
  logic [DATA-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_is_wr;
  logic            rsp_err;
  logic [DATA-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_is_wr, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_is_wr, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/dev_mem_arbiter.sv
// Single-port device RAM controller: optional zero-fill after reset, then
// round-robin sharing between host (h) and maintenance (m) requesters.
module dev_mem_arbiter #(
  parameter int ADDR  = 16,
  parameter int DATA  = 128,
  parameter int DEPTH = 65536
) (
  input  logic                fm_clk,
  input  logic                fm_rst,
  input  logic                init_en,
  output logic                init_done,
  dev_mem_arbiter_if.slave    h,
  dev_mem_arbiter_if.slave    m,
  output logic                ram_we,
  output logic [ADDR-1:0]     ram_addr,
  output logic [DATA-1:0]     ram_wdata,
  input  logic [DATA-1:0]     ram_rdata
);
  localparam logic [ADDR:0]   DEPTH_W   = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  typedef enum logic [1:0] {ST_START, ST_FILL, ST_RUN} state_t;

  state_t          state_reg, state_next;
  logic [ADDR-1:0] fill_reg, fill_next;
  logic            last_host_reg, last_host_next;
  logic [ADDR-1:0] addr_reg;
  logic [DATA-1:0] wdata_reg;
  logic            rsp_h_reg, rsp_m_reg, rsp_wr_reg, rsp_err_reg;

  logic            gnt_h, gnt_m, fire, fill_we;
  logic            sel_we, sel_in_range;
  logic [ADDR-1:0] sel_addr;
  logic [DATA-1:0] sel_wdata;

  // On a tie the side that did not win last time gets the slot.
  always_comb begin
    gnt_h = 1'b0;
    gnt_m = 1'b0;
    if (state_reg == ST_RUN) begin
      gnt_h = h.req_valid && (!m.req_valid || !last_host_reg);
      gnt_m = m.req_valid && (!h.req_valid ||  last_host_reg);
    end
  end

  assign fire         = gnt_h | gnt_m;
  assign sel_we       = gnt_h ? h.req_we    : m.req_we;
  assign sel_addr     = gnt_h ? h.req_addr  : m.req_addr;
  assign sel_wdata    = gnt_h ? h.req_wdata : m.req_wdata;
  assign sel_in_range = {1'b0, sel_addr} < DEPTH_W;

  always_comb begin
    state_next     = state_reg;
    fill_next      = fill_reg;
    fill_we        = 1'b0;
    last_host_next = fire ? gnt_h : last_host_reg;
    case (state_reg)
      ST_START: begin
        // init_en only matters in this very first cycle after reset.
        if (init_en) begin
          fill_we = 1'b1;
          if (LAST_ADDR == '0) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_FILL;
            fill_next  = fill_reg + ADDR'(1);
          end
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_FILL: begin
        fill_we = 1'b1;
        if (fill_reg == LAST_ADDR) begin
          state_next = ST_RUN;
        end else begin
          fill_next = fill_reg + ADDR'(1);
        end
      end
      default: ;
    endcase
  end

  // The reset gate keeps the fill strobe quiet while reset is still held.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_reg;
    ram_wdata = wdata_reg;
    if (state_reg != ST_RUN) begin
      ram_we    = fill_we & fm_rst;
      ram_addr  = fill_reg;
      ram_wdata = '0;
    end else if (fire) begin
      ram_we    = sel_we & sel_in_range;
      ram_addr  = sel_addr;
      ram_wdata = sel_wdata;
    end
  end

  always_ff @(posedge fm_clk or negedge fm_rst) begin
    if (!fm_rst) begin
      state_reg     <= ST_START;
      fill_reg      <= '0;
      last_host_reg <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_h_reg     <= 1'b0;
      rsp_m_reg     <= 1'b0;
      rsp_wr_reg    <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fill_reg      <= fill_next;
      last_host_reg <= last_host_next;
      addr_reg      <= ram_addr;
      wdata_reg     <= ram_wdata;
      rsp_h_reg     <= gnt_h;
      rsp_m_reg     <= gnt_m;
      rsp_wr_reg    <= sel_we;
      rsp_err_reg   <= !sel_in_range;
    end
  end

  assign init_done   = (state_reg == ST_RUN);
  assign h.req_ready = gnt_h;
  assign m.req_ready = gnt_m;

  // Read data is passed through only for in-range reads; acks and errors return zero.
  assign h.rsp_valid = rsp_h_reg;
  assign h.rsp_is_wr = rsp_h_reg & rsp_wr_reg;
  assign h.rsp_err   = rsp_h_reg & rsp_err_reg;
  assign h.rsp_rdata = (rsp_h_reg && !rsp_wr_reg && !rsp_err_reg) ? ram_rdata : '0;
  assign m.rsp_valid = rsp_m_reg;
  assign m.rsp_is_wr = rsp_m_reg & rsp_wr_reg;
  assign m.rsp_err   = rsp_m_reg & rsp_err_reg;
  assign m.rsp_rdata = (rsp_m_reg && !rsp_wr_reg && !rsp_err_reg) ? ram_rdata : '0;
endmodule

// File: tb/tb_dev_mem_arbiter.sv
// Bench for dev_mem_arbiter: small RAM fixture, behavioural memory/arbitration
// model, directed scenarios plus randomized two-requester traffic.
module tb_dev_mem_arbiter;
  localparam int ADDR  = 8;
  localparam int DATA  = 32;
  localparam int DEPTH = 16;
  localparam logic [DATA-1:0] PRE = 32'hA5A5_A5A5;
  localparam logic [DATA+2:0] RSP_RD0 = {3'b100, {DATA{1'b0}}};

  logic            fm_clk  = 1'b0;
  logic            fm_rst  = 1'b0;
  logic            init_en = 1'b0;
  logic            init_done;
  logic            ram_we;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_wdata;
  logic [DATA-1:0] ram_rdata;
  logic            preload = 1'b0;
  logic [DATA-1:0] ram [DEPTH];

  dev_mem_arbiter_if #(.ADDR(ADDR), .DATA(DATA)) h ();
  dev_mem_arbiter_if #(.ADDR(ADDR), .DATA(DATA)) m ();

  dev_mem_arbiter #(.ADDR(ADDR), .DATA(DATA), .DEPTH(DEPTH)) dut (
    .fm_clk(fm_clk), .fm_rst(fm_rst), .init_en(init_en), .init_done(init_done),
    .h(h), .m(m),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 fm_clk = ~fm_clk;

  // Single-port RAM with registered read (read-before-write in the same cycle).
  always @(posedge fm_clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= PRE;
    end else if (ram_we && ram_addr < ADDR'(DEPTH)) begin
      ram[ram_addr[3:0]] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr[3:0]];
  end

  logic [DATA-1:0] mdl_mem [DEPTH];
  bit              mdl_last_host, exp_h_v, exp_m_v, exp_wr, exp_err, have_last;
  logic [DATA-1:0] exp_rd, exp_wdata_hold;
  logic [ADDR-1:0] exp_addr_hold;
  int              checks = 0;
  int              errors = 0;

  wire [DATA+2:0] act_h = {h.rsp_valid, h.rsp_is_wr, h.rsp_err, h.rsp_rdata};
  wire [DATA+2:0] act_m = {m.rsp_valid, m.rsp_is_wr, m.rsp_err, m.rsp_rdata};

  function automatic logic [DATA+2:0] exp_rsp(input bit v);
    return v ? {1'b1, exp_wr, exp_err, exp_rd} : '0;
  endfunction

  task automatic model_reset(input logic [DATA-1:0] fill);
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = fill;
    mdl_last_host = 1'b0;
    exp_h_v = 1'b0;
    exp_m_v = 1'b0;
    have_last = 1'b0;
  endtask

  // Decides this cycle's winner from the current requests and updates the memory image.
  task automatic model_cycle(output int win);
    logic            we;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] wd;
    if (h.req_valid && m.req_valid) win = mdl_last_host ? 2 : 1;
    else if (h.req_valid)           win = 1;
    else if (m.req_valid)           win = 2;
    else                            win = 0;
    exp_h_v = (win == 1);
    exp_m_v = (win == 2);
    if (win != 0) begin
      we   = (win == 1) ? h.req_we    : m.req_we;
      addr = (win == 1) ? h.req_addr  : m.req_addr;
      wd   = (win == 1) ? h.req_wdata : m.req_wdata;
      exp_wr  = we;
      exp_err = (addr >= ADDR'(DEPTH));
      exp_rd  = (!we && !exp_err) ? mdl_mem[addr[3:0]] : '0;
      if (we && !exp_err) mdl_mem[addr[3:0]] = wd;
      mdl_last_host  = (win == 1);
      have_last      = 1'b1;
      exp_addr_hold  = addr;
      exp_wdata_hold = wd;
    end
  endtask

  task automatic drive(input bit hv, input bit hwe, input logic [ADDR-1:0] ha, input logic [DATA-1:0] hd,
                       input bit mv, input bit mwe, input logic [ADDR-1:0] ma, input logic [DATA-1:0] md);
    h.req_valid = hv; h.req_we = hwe; h.req_addr = ha; h.req_wdata = hd;
    m.req_valid = mv; m.req_we = mwe; m.req_addr = ma; m.req_wdata = md;
  endtask

  task automatic apply_reset(input bit en, input bit pre);
    fm_rst  = 1'b0;
    init_en = en;
    drive(0, 0, 0, '0, 0, 0, 0, '0);
    preload = pre;
    @(negedge fm_clk);
    preload = 1'b0;
    @(negedge fm_clk);
    fm_rst = 1'b1;
  endtask

  task automatic test_reset();
    fm_rst  = 1'b0;
    init_en = 1'b1;
    drive(1, 1, 3, '1, 1, 1, 4, '1);
    repeat (2) @(negedge fm_clk);
    #1;
    checks++;
    if ({ram_we, init_done, h.req_ready, m.req_ready, h.rsp_valid, m.rsp_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {ram_we, init_done, h.req_ready, m.req_ready, h.rsp_valid, m.rsp_valid});
    end
    checks++;
    if ({ram_addr, ram_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus got addr %h data %h want 0", ram_addr, ram_wdata);
    end
    checks++;
    if ({h.rsp_rdata, m.rsp_rdata, h.rsp_is_wr, h.rsp_err, m.rsp_is_wr, m.rsp_err} !== '0) begin
      errors++; $display("FAIL reset_rsp got h %h m %h want 0", act_h, act_m);
    end
  endtask

  task automatic test_fill();
    int win;
    apply_reset(1'b1, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 0, ADDR'(k), '0, 1, 1, ADDR'(k), '1);
      #1;
      checks++;
      if ({ram_we, ram_addr, ram_wdata} !== {1'b1, ADDR'(k), {DATA{1'b0}}}) begin
        errors++;
        $display("FAIL fill_write cyc %0d got we %b addr %0d data %h want we 1 addr %0d data 0",
                 k, ram_we, ram_addr, ram_wdata, k);
      end
      checks++;
      if ({init_done, h.req_ready, m.req_ready} !== 3'b000) begin
        errors++;
        $display("FAIL fill_idle cyc %0d got done/rdy %b want 000", k, {init_done, h.req_ready, m.req_ready});
      end
      @(negedge fm_clk);
    end
    drive(0, 0, 0, '0, 0, 0, 0, '0);
    #1;
    checks++;
    if ({init_done, ram_we} !== 2'b10) begin
      errors++; $display("FAIL fill_done cyc %0d got done %b we %b want done 1 we 0", DEPTH, init_done, ram_we);
    end
    model_reset('0);
    model_cycle(win);
    @(negedge fm_clk);
  endtask

  task automatic test_alternate();
    int win;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        checks++;
        if (act_h !== ((c % 2 == 1) ? RSP_RD0 : '0)) begin
          errors++; $display("FAIL alt_rsp_h cyc %0d got %h want %h", c, act_h, (c % 2 == 1) ? RSP_RD0 : '0);
        end
        checks++;
        if (act_m !== ((c % 2 == 0) ? RSP_RD0 : '0)) begin
          errors++; $display("FAIL alt_rsp_m cyc %0d got %h want %h", c, act_m, (c % 2 == 0) ? RSP_RD0 : '0);
        end
      end
      if (c < 6) drive(1, 0, 1, '0, 1, 0, 2, '0);
      else       drive(0, 0, 0, '0, 0, 0, 0, '0);
      #1;
      model_cycle(win);
      if (c < 6) begin
        checks++;
        if ({h.req_ready, m.req_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL alt_grant cyc %0d got h/m ready %b want %b", c, {h.req_ready, m.req_ready},
                   (c % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      @(negedge fm_clk);
    end
  endtask

  task automatic test_raw();
    int win;
    drive(1, 1, 3, 32'h1234, 0, 0, 0, '0);
    #1;
    model_cycle(win);
    checks++;
    if ({h.req_ready, ram_we, ram_addr, ram_wdata} !== {2'b11, ADDR'(3), DATA'(32'h1234)}) begin
      errors++;
      $display("FAIL raw_write got rdy %b we %b addr %0d data %h want 1 1 3 1234",
               h.req_ready, ram_we, ram_addr, ram_wdata);
    end
    @(negedge fm_clk);
    checks++;
    if (act_h !== {3'b110, {DATA{1'b0}}}) begin
      errors++; $display("FAIL raw_ack got %h want %h", act_h, {3'b110, {DATA{1'b0}}});
    end
    drive(1, 0, 3, '0, 0, 0, 0, '0);
    #1;
    model_cycle(win);
    checks++;
    if ({h.req_ready, ram_we, ram_addr} !== {2'b10, ADDR'(3)}) begin
      errors++; $display("FAIL raw_read got rdy %b we %b addr %0d want 1 0 3", h.req_ready, ram_we, ram_addr);
    end
    @(negedge fm_clk);
    checks++;
    if (act_h !== {3'b100, DATA'(32'h1234)}) begin
      errors++; $display("FAIL raw_data got %h want %h", act_h, {3'b100, DATA'(32'h1234)});
    end
    drive(0, 0, 0, '0, 0, 0, 0, '0);
    #1;
    model_cycle(win);
    @(negedge fm_clk);
  endtask

  task automatic test_oob();
    int win;
    drive(0, 0, 0, '0, 1, 0, 16, '0);
    #1;
    model_cycle(win);
    checks++;
    if ({m.req_ready, ram_we} !== 2'b10) begin
      errors++; $display("FAIL oob_rd_req got rdy %b we %b want 1 0", m.req_ready, ram_we);
    end
    @(negedge fm_clk);
    checks++;
    if (act_m !== {3'b101, {DATA{1'b0}}} || h.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL oob_rd_rsp got m %h h_valid %b want %h 0", act_m, h.rsp_valid, {3'b101, {DATA{1'b0}}});
    end
    drive(1, 1, 20, '1, 0, 0, 0, '0);
    #1;
    model_cycle(win);
    checks++;
    if ({h.req_ready, ram_we} !== 2'b10) begin
      errors++; $display("FAIL oob_wr_req got rdy %b we %b want 1 0", h.req_ready, ram_we);
    end
    @(negedge fm_clk);
    checks++;
    if (act_h !== {3'b111, {DATA{1'b0}}}) begin
      errors++; $display("FAIL oob_wr_rsp got %h want %h", act_h, {3'b111, {DATA{1'b0}}});
    end
    drive(0, 0, 0, '0, 0, 0, 0, '0);
    #1;
    model_cycle(win);
    @(negedge fm_clk);
  endtask

  task automatic test_random(input int n);
    int              win;
    bit              hv, mv, hwe, mwe;
    logic [ADDR-1:0] ha, ma;
    logic [DATA-1:0] hd, md;
    hv = 0; mv = 0; hwe = 0; mwe = 0; ha = '0; ma = '0; hd = '0; md = '0;
    for (int c = 0; c <= n; c++) begin
      checks++;
      if (act_h !== exp_rsp(exp_h_v)) begin
        errors++; $display("FAIL rnd_rsp_h cyc %0d got %h want %h", c, act_h, exp_rsp(exp_h_v));
      end
      checks++;
      if (act_m !== exp_rsp(exp_m_v)) begin
        errors++; $display("FAIL rnd_rsp_m cyc %0d got %h want %h", c, act_m, exp_rsp(exp_m_v));
      end
      // A requester keeps its pending request unchanged until it is granted.
      if (!hv) begin
        hv = ($urandom_range(0, 3) != 0); hwe = $urandom_range(0, 1);
        ha = ADDR'($urandom_range(0, DEPTH + 3)); hd = $urandom;
      end
      if (!mv) begin
        mv = ($urandom_range(0, 3) != 0); mwe = $urandom_range(0, 1);
        ma = ADDR'($urandom_range(0, DEPTH + 3)); md = $urandom;
      end
      if (c == n) begin hv = 0; mv = 0; end
      drive(hv, hwe, ha, hd, mv, mwe, ma, md);
      #1;
      model_cycle(win);
      checks++;
      if ({h.req_ready, m.req_ready} !== {win == 1, win == 2}) begin
        errors++; $display("FAIL rnd_grant cyc %0d got h/m ready %b want %b", c,
                           {h.req_ready, m.req_ready}, {win == 1, win == 2});
      end
      if (win != 0 || have_last) begin
        checks++;
        if ({ram_we, ram_addr, ram_wdata} !== {(win != 0) && exp_wr && !exp_err, exp_addr_hold, exp_wdata_hold}) begin
          errors++;
          $display("FAIL rnd_ram cyc %0d got we %b addr %0d data %h want we %b addr %0d data %h", c,
                   ram_we, ram_addr, ram_wdata, (win != 0) && exp_wr && !exp_err, exp_addr_hold, exp_wdata_hold);
        end
      end
      if (win == 1) hv = 0;
      if (win == 2) mv = 0;
      @(negedge fm_clk);
    end
  endtask

  task automatic test_abort_fill();
    apply_reset(1'b1, 1'b0);
    repeat (7) @(negedge fm_clk);
    #1;
    checks++;
    if ({ram_we, ram_addr} !== {1'b1, ADDR'(7)}) begin
      errors++; $display("FAIL abort_pre got we %b addr %0d want 1 7", ram_we, ram_addr);
    end
    fm_rst = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_wdata, init_done} !== '0) begin
      errors++; $display("FAIL abort_clear got we %b addr %0d done %b want 0", ram_we, ram_addr, init_done);
    end
    @(negedge fm_clk);
    fm_rst = 1'b1;
    #1;
    checks++;
    if ({ram_we, ram_addr, h.rsp_valid, m.rsp_valid} !== {1'b1, ADDR'(0), 2'b00}) begin
      errors++; $display("FAIL abort_restart got we %b addr %0d rsp %b%b want 1 0 00",
                         ram_we, ram_addr, h.rsp_valid, m.rsp_valid);
    end
    repeat (DEPTH) @(negedge fm_clk);
    #1;
    checks++;
    if (init_done !== 1'b1) begin
      errors++; $display("FAIL abort_done got %b want 1", init_done);
    end
    @(negedge fm_clk);
  endtask

  task automatic test_abort_rsp();
    drive(1, 0, 2, '0, 0, 0, 0, '0);
    #1;
    checks++;
    if (h.req_ready !== 1'b1) begin
      errors++; $display("FAIL drop_grant got %b want 1", h.req_ready);
    end
    fm_rst = 1'b0;
    @(negedge fm_clk);
    checks++;
    if ({act_h, act_m} !== '0) begin
      errors++; $display("FAIL drop_rsp got h %h m %h want 0", act_h, act_m);
    end
    drive(0, 0, 0, '0, 0, 0, 0, '0);
    init_en = 1'b0;
    fm_rst  = 1'b1;
    #1;
    checks++;
    if ({ram_we, init_done, h.rsp_valid, m.rsp_valid} !== 4'b0) begin
      errors++; $display("FAIL drop_after got we %b done %b rsp %b%b want 0", ram_we, init_done,
                         h.rsp_valid, m.rsp_valid);
    end
    @(negedge fm_clk);
    model_reset('0);
  endtask

  task automatic test_no_init();
    int win;
    apply_reset(1'b0, 1'b1);
    model_reset(PRE);
    #1;
    checks++;
    if ({ram_we, init_done} !== 2'b00) begin
      errors++; $display("FAIL noinit_c0 got we %b done %b want 0 0", ram_we, init_done);
    end
    @(negedge fm_clk);
    drive(1, 0, 5, '0, 0, 0, 0, '0);
    #1;
    model_cycle(win);
    checks++;
    if ({ram_we, init_done, h.req_ready} !== 3'b011) begin
      errors++; $display("FAIL noinit_c1 got we %b done %b rdy %b want 0 1 1", ram_we, init_done, h.req_ready);
    end
    @(negedge fm_clk);
    checks++;
    if (act_h !== {3'b100, PRE}) begin
      errors++; $display("FAIL noinit_read got %h want %h", act_h, {3'b100, PRE});
    end
    drive(0, 0, 0, '0, 0, 0, 0, '0);
    #1;
    model_cycle(win);
    @(negedge fm_clk);
  endtask

  initial begin
    drive(0, 0, 0, '0, 0, 0, 0, '0);
    test_reset();
    test_fill();
    test_alternate();
    test_raw();
    test_oob();
    test_random(200);
    test_abort_fill();
    test_abort_rsp();
    test_no_init();
    test_random(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
